// File: rtl/boson_video_pkg.sv
// boson_video_pkg: pattern selectors, FSM state type and default Boson timing constants.
package boson_video_pkg;

    localparam logic [1:0] PAT_STRIPE = 2'd0;
    localparam logic [1:0] PAT_HRAMP  = 2'd1;
    localparam logic [1:0] PAT_VRAMP  = 2'd2;
    localparam logic [1:0] PAT_FCOUNT = 2'd3;

    localparam int DEF_DATA_W        = 16;
    localparam int DEF_LINE_CLKS     = 1711;
    localparam int DEF_FRAME_LINES   = 263;
    localparam int DEF_VBLANK_LINES  = 7;
    localparam int DEF_HSYNC_CLKS    = 7;
    localparam int DEF_ACTIVE_START  = 693;
    localparam int DEF_ACTIVE_PIXELS = 320;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/boson_pattern_gen_if.sv
// boson_pattern_gen_if: control inputs and CMOS-style video outputs of the pattern source.
interface boson_pattern_gen_if #(
    parameter int DATA_W = 16
);

    logic              pix_ce;
    logic              enable;
    logic [1:0]        mode;
    logic [DATA_W-1:0] cmos_dq;
    logic              cmos_vsync;
    logic              cmos_hsync;
    logic              cmos_valid;
    logic              frame_start;
    logic [15:0]       frame_count;

    modport master (
        input  pix_ce, enable, mode,
        output cmos_dq, cmos_vsync, cmos_hsync, cmos_valid, frame_start, frame_count
    );

    modport slave (
        output pix_ce, enable, mode,
        input  cmos_dq, cmos_vsync, cmos_hsync, cmos_valid, frame_start, frame_count
    );

endinterface

// File: rtl/boson_timing_counter.sv
// boson_timing_counter: h/v raster counters advancing on adv_i; exposes post-update values and end-of-frame.
module boson_timing_counter #(
    parameter  int LINE_CLKS   = 1711,
    parameter  int FRAME_LINES = 263,
    localparam int HW          = $clog2(LINE_CLKS),
    localparam int VW          = $clog2(FRAME_LINES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv_i,
    output logic [HW-1:0] h_nxt_o,
    output logic [VW-1:0] v_nxt_o,
    output logic          eof_o
);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_end, v_end;

    always_comb begin
        h_end = h_q == HW'(LINE_CLKS - 1);
        v_end = v_q == VW'(FRAME_LINES - 1);
        h_d   = adv_i ? (h_end ? '0 : h_q + 1'b1) : h_q;
        v_d   = (adv_i && h_end) ? (v_end ? '0 : v_q + 1'b1) : v_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_nxt_o = h_d;
    assign v_nxt_o = v_d;
    assign eof_o   = h_end && v_end;

endmodule

// File: rtl/boson_pattern_gen.sv
// boson_pattern_gen: Boson-style CMOS video source with VSYNC/HSYNC/VALID timing and four test patterns.
module boson_pattern_gen
    import boson_video_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int LINE_CLKS     = DEF_LINE_CLKS,
    parameter int FRAME_LINES   = DEF_FRAME_LINES,
    parameter int VBLANK_LINES  = DEF_VBLANK_LINES,
    parameter int HSYNC_CLKS    = DEF_HSYNC_CLKS,
    parameter int ACTIVE_START  = DEF_ACTIVE_START,
    parameter int ACTIVE_PIXELS = DEF_ACTIVE_PIXELS
) (
    input  logic                clk,
    input  logic                reset,
    boson_pattern_gen_if.master vid
);

    localparam int HW = $clog2(LINE_CLKS);
    localparam int VW = $clog2(FRAME_LINES);

    if (ACTIVE_START + ACTIVE_PIXELS > LINE_CLKS) begin : g_bad_active
        $error("active window exceeds line length");
    end
    if (VBLANK_LINES >= FRAME_LINES) begin : g_bad_vblank
        $error("vertical blank must be shorter than the frame");
    end
    if (HSYNC_CLKS >= LINE_CLKS) begin : g_bad_hsync
        $error("hsync prefix must be shorter than the line");
    end

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       fc_q, fc_d;
    logic [DATA_W-1:0] dq_q, dq_d, pat;
    logic              vs_q, vs_d, hs_q, hs_d, va_q, va_d, fs_q, fs_d;
    logic              adv, eof;
    logic [HW-1:0]     h_n, x;
    logic [VW-1:0]     v_n, y;

    assign adv = vid.pix_ce && state_q == ST_RUN;

    boson_timing_counter #(
        .LINE_CLKS  (LINE_CLKS),
        .FRAME_LINES(FRAME_LINES)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .adv_i  (adv),
        .h_nxt_o(h_n),
        .v_nxt_o(v_n),
        .eof_o  (eof)
    );

    // Outputs depend only on state, counters, mode_q and fc_q, so they hold naturally between strobes.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fc_d    = fc_q;
        fs_d    = 1'b0;
        if (vid.pix_ce && state_q == ST_IDLE && vid.enable) begin
            state_d = ST_RUN;
            mode_d  = vid.mode;
            fs_d    = 1'b1;
        end else if (adv && eof) begin
            fc_d    = fc_q + 16'd1;
            mode_d  = vid.enable ? vid.mode : mode_q;
            fs_d    = vid.enable;
            state_d = vid.enable ? ST_RUN : ST_IDLE;
        end
        x    = h_n - HW'(ACTIVE_START);
        y    = v_n - VW'(VBLANK_LINES);
        vs_d = state_d == ST_RUN && 32'(v_n) >= VBLANK_LINES;
        hs_d = vs_d && 32'(h_n) >= HSYNC_CLKS;
        va_d = vs_d && 32'(h_n) >= ACTIVE_START && 32'(h_n) < ACTIVE_START + ACTIVE_PIXELS;
        pat  = mode_d == PAT_STRIPE ? {DATA_W{~x[1]}} :
               mode_d == PAT_HRAMP  ? DATA_W'(x) :
               mode_d == PAT_VRAMP  ? DATA_W'(y) : DATA_W'(fc_q);
        dq_d = va_d ? pat : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            fc_q    <= '0;
            dq_q    <= '0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            va_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fc_q    <= fc_d;
            dq_q    <= dq_d;
            vs_q    <= vs_d;
            hs_q    <= hs_d;
            va_q    <= va_d;
            fs_q    <= fs_d;
        end
    end

    assign vid.cmos_dq     = dq_q;
    assign vid.cmos_vsync  = vs_q;
    assign vid.cmos_hsync  = hs_q;
    assign vid.cmos_valid  = va_q;
    assign vid.frame_start = fs_q;
    assign vid.frame_count = fc_q;

endmodule

// File: doc/boson_pattern_gen.md
Name: boson_pattern_gen

Overview:
Synthesisable, parametrised Boson-style CMOS video source that generates VSYNC/HSYNC/VALID timing and a 16-bit (DATA_W) pixel bus from the system clock. Pixel rate is set by a pixel-strobe input, so the block can emulate the 13.5 MHz camera on the fabric clock. It is selected in place of the camera pins for on-board bring-up of the capture/SD path. Four runtime-selectable test patterns are provided; mode changes apply only at frame boundaries.

Parameters:
DATA_W, 16, pixel bus width
LINE_CLKS, 1711, pixel periods per line (h counter modulus)
FRAME_LINES, 263, lines per frame (v counter modulus)
VBLANK_LINES, 7, leading lines with VSYNC low
HSYNC_CLKS, 7, leading pixel periods per line with HSYNC low
ACTIVE_START, 693, h index of first valid pixel
ACTIVE_PIXELS, 320, valid pixels per line

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel strobe; all counters and outputs advance only on cycles where pix_ce=1
enable  in  1  run request; sampled at frame boundaries
mode  in  2  pattern select; sampled at frame start
cmos_dq  out  DATA_W  pixel data
cmos_vsync  out  1  high during the active-line region
cmos_hsync  out  1  high after the HSYNC_CLKS prefix of each active-region line
cmos_valid  out  1  pixel qualifier
frame_start  out  1  one-clk pulse coinciding with the h=0,v=0 output update
frame_count  out  16  completed-frame counter; wraps at 0xFFFF->0

Behaviour:
- Reset (sync, active-high): state=IDLE; h=v=0; every output 0 (including frame_count) on the clk edge following reset assertion. Applies mid-frame with no flush.
- States: IDLE and RUN.
  - IDLE -> RUN on a cycle with enable=1 and pix_ce=1: h=0, v=0, mode_q<=mode, frame_start=1.
  - RUN: on each pix_ce, h increments. At h=LINE_CLKS-1, h->0 and v increments. At v=FRAME_LINES-1 with h=LINE_CLKS-1, frame_count increments, and:
    - if enable=1: v->0, mode_q<=mode, frame_start pulses;
    - else: -> IDLE.
  - enable deassert mid-frame: the current frame completes.
- Outputs are registered from the post-update h/v: latency 1 clk after the pix_ce edge. Outputs hold between strobes. frame_start is high for one clk only, even if pix_ce is continuous.
- Output decode:
  - vsync = RUN && v>=VBLANK_LINES
  - hsync = vsync && h>=HSYNC_CLKS
  - valid = vsync && ACTIVE_START<=h<ACTIVE_START+ACTIVE_PIXELS
- Pixel coordinates: x=h-ACTIVE_START, y=v-VBLANK_LINES. Widths are $clog2 of the moduli; values are zero-extended or truncated to DATA_W.
- cmos_dq = 0 whenever valid=0. Otherwise, by mode_q:
  - 0: stripe, all-ones if x[1]==0 else 0 (period 4: 2 high, 2 low)
  - 1: horizontal ramp, x
  - 2: vertical ramp, y
  - 3: frame_count[DATA_W-1:0] (value before the end-of-frame increment)
- mode changes mid-frame are ignored until the next frame start.
- IDLE: all outputs 0, frame_count held.
- Elaboration assertions:
  - ACTIVE_START+ACTIVE_PIXELS <= LINE_CLKS
  - VBLANK_LINES < FRAME_LINES
  - HSYNC_CLKS < LINE_CLKS

Decomposition:
- Package boson_video_pkg holds:
  - mode constants: PAT_STRIPE=0, PAT_HRAMP=1, PAT_VRAMP=2, PAT_FCOUNT=3
  - default timing constants: 1711, 263, 7, 7, 693, 320
- One sub-module, boson_timing_counter: h/v counters with pix_ce, wrap, and the end-of-frame flag. Pattern mux and the IDLE/RUN FSM stay in the top.

Test Plan:
Test params unless stated: LINE_CLKS=20, FRAME_LINES=6, VBLANK=2, HSYNC=2, ACTIVE_START=8, ACTIVE_PIXELS=8, pix_ce=1.
1. Reset, enable=1, mode=0 -> frame_start one clk after the strobe. vsync low for 40 pixel periods. Each active line: hsync low for 2, valid for h=8..15, dq=FFFF,FFFF,0000,0000 repeated.
2. mode=1, then mode=2 -> mode 1: dq=0..7 each line. Mode 2: dq=0,1,2,3 on lines v=2..5.
3. Toggle mode 0->1 mid-frame -> current frame keeps the stripe; the next frame shows the ramp.
4. pix_ce every 3rd clk -> timing identical in strobe units; outputs held for 3 clks; frame_start is a single clk.
5. Drop enable at v=3 -> frame completes; frame_count increments 0->1; IDLE outputs all 0. Re-raise enable -> restart at h=v=0.
6. Assert reset at v=4,h=10 with valid=1 -> next clk all outputs 0, including frame_count. Also run defaults for 2 frames -> 1711*263 strobes/frame, 256 valid lines, 320 valid pixels/line, frame_count=2.
